mem_fill_ctrl: RTL

- Cache-miss fill controller that sits directly upstream of the pipelined cpu core, between the core's I-cache/D-cache miss logic and the single-ported, pipelined 4-cycle-latency main memory.
- Arbitrates between instruction and data misses and streams one 8-word block per miss into the requesting cache.
- Pulses a completion strobe to the requester when the block is in.
- Its busy output feeds the core's pipeline stall.

---
 rtl/mem_fill_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_fill_ctrl.sv
// mem_fill_ctrl: arbitrates I/D cache misses (D first) and streams one block
// per miss from pipelined memory into the requesting cache.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   icache_miss/_addr             I-cache miss request and byte address
//   dcache_miss/_addr             D-cache miss request and byte address
//   mem_data_valid, mem_data_in   memory read return
//   mem_en, mem_addr              memory read request
//   fill_we_i/_d, fill_word,      cache data-array write port
//   fill_data
//   fill_done_i/_d                block-complete strobe (tag/valid write)
//   busy                          pipeline stall, high outside IDLE
module mem_fill_ctrl #(
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LAT     = 4,
  parameter int ADDR_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           icache_miss,
  input  logic [ADDR_W-1:0]              icache_miss_addr,
  input  logic                           dcache_miss,
  input  logic [ADDR_W-1:0]              dcache_miss_addr,
  input  logic                           mem_data_valid,
  input  logic [15:0]                    mem_data_in,
  output logic                           mem_en,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic                           fill_we_i,
  output logic                           fill_we_d,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic [15:0]                    fill_data,
  output logic                           fill_done_i,
  output logic                           fill_done_d,
  output logic                           busy
);

  localparam int WORD_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W  = $clog2(2 * BLOCK_WORDS);
  localparam int CNT_W  = WORD_W + 1;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_WORDS - 1);

  localparam logic [ADDR_W-1:0] OFF_MASK =
    ADDR_W'((1 << OFF_W) - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (MEM_LAT < 1) begin : g_lat_chk
    $error("MEM_LAT must be at least 1");
  end

  logic [1:0]        state;
  logic              grant_d;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  req_cnt;
  logic [CNT_W-1:0]  rcv_cnt;

  logic in_fill;
  logic req_act;
  logic ret_act;

  assign in_fill = (state == FILL);
  assign req_act = in_fill && (req_cnt < FULL);
  // Returns outside FILL (e.g. stale reads after reset) are dropped.
  assign ret_act = in_fill && mem_data_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_d <= 1'b0;
      base    <= '0;
      req_cnt <= '0;
      rcv_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dcache_miss) begin
            grant_d <= 1'b1;
            base    <= dcache_miss_addr & ~OFF_MASK;
            req_cnt <= '0;
            rcv_cnt <= '0;
            state   <= FILL;
          end else if (icache_miss) begin
            grant_d <= 1'b0;
            base    <= icache_miss_addr & ~OFF_MASK;
            req_cnt <= '0;
            rcv_cnt <= '0;
            state   <= FILL;
          end
        end
        FILL: begin
          if (req_act) begin
            req_cnt <= req_cnt + 1'b1;
          end
          if (ret_act) begin
            rcv_cnt <= rcv_cnt + 1'b1;
            if (rcv_cnt == LAST) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Sum truncates to ADDR_W: a block at the top of memory does not carry.
  assign mem_en   = req_act;
  assign mem_addr = req_act ?
                    base + ADDR_W'({req_cnt, 1'b0}) : '0;

  assign fill_we_i = ret_act && !grant_d;
  assign fill_we_d = ret_act && grant_d;
  assign fill_word = ret_act ? rcv_cnt[WORD_W-1:0] : '0;
  assign fill_data = ret_act ? mem_data_in : '0;

  assign fill_done_i = (state == DONE) && !grant_d;
  assign fill_done_d = (state == DONE) && grant_d;
  assign busy        = (state != IDLE);

endmodule
